// File: rtl/gpio_pad_bank_ctrl.sv
// gpio_pad_bank_ctrl
//
// Controller for a bank of NUM_PINS sky130 GPIOv2 pad cells. It powers the pad
// high-voltage domain up in three timed steps and then passes the registered
// per-pin configuration through to the pads. It can freeze the pads in a hold
// state on request. It also synchronises the pad inputs and raises sticky
// per-pin edge interrupts.
//
// Optional feature: define GPIO_PAD_BANK_DEBOUNCE_EN to insert a per-pin
// debounce filter between the synchroniser and gpio_in.
//
// Ports
//   clock, reset_n       bank clock, async active-low reset
//   cfg_out/oe/dm        per-pin output value, output enable, drive mode (3b/pin)
//   cfg_inp_dis          per-pin input buffer disable
//   cfg_irq_rise/fall    per-pin edge interrupt enables
//   irq_clr              write-1-to-clear pulse for irq_status
//   hold_req             request pad hold (freeze)
//   pad_in               pad IN outputs
//   pad_out/oe_n/dm/inp_dis   per-pin pad controls
//   pad_enable_h, pad_enable_inp_h, pad_hld_h_n   shared pad HV controls
//   gpio_in              synchronised (optionally debounced) inputs
//   irq_status, irq      sticky edge flags and their OR
//   ready                bank operational
//
// state    | meaning
// ---------+-----------------------------------------------------------
// OFF      | just out of reset, all HV enables low
// EN_H     | pad_enable_h high, waiting PWR_DELAY cycles
// EN_INP   | pad_enable_inp_h high as well, waiting PWR_DELAY cycles
// RELEASE  | pad_hld_h_n released, waiting PWR_DELAY cycles
// READY    | configuration passes through to the pads
// HOLD     | pad_hld_h_n low, pad controls frozen

module gpio_pad_bank_ctrl #(
  parameter int NUM_PINS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int PWR_DELAY       = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_PINS-1:0]   cfg_out,
  input  logic [NUM_PINS-1:0]   cfg_oe,
  input  logic [3*NUM_PINS-1:0] cfg_dm,
  input  logic [NUM_PINS-1:0]   cfg_inp_dis,
  input  logic [NUM_PINS-1:0]   cfg_irq_rise,
  input  logic [NUM_PINS-1:0]   cfg_irq_fall,
  input  logic [NUM_PINS-1:0]   irq_clr,
  input  logic                  hold_req,
  input  logic [NUM_PINS-1:0]   pad_in,
  output logic [NUM_PINS-1:0]   pad_out,
  output logic [NUM_PINS-1:0]   pad_oe_n,
  output logic [NUM_PINS-1:0]   pad_inp_dis,
  output logic [3*NUM_PINS-1:0] pad_dm,
  output logic                  pad_enable_h,
  output logic                  pad_enable_inp_h,
  output logic                  pad_hld_h_n,
  output logic [NUM_PINS-1:0]   gpio_in,
  output logic [NUM_PINS-1:0]   irq_status,
  output logic                  irq,
  output logic                  ready
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_EN_H,
    ST_EN_INP,
    ST_RELEASE,
    ST_READY,
    ST_HOLD
  } state_t;

  localparam logic [7:0]            DLY_LOAD = 8'(PWR_DELAY - 1);
  localparam logic [3*NUM_PINS-1:0] DM_SAFE  = {NUM_PINS{3'b001}};

  state_t              state, state_next;
  logic [7:0]          dly_cnt, dly_cnt_next;
  logic                active;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync_out;
  logic [NUM_PINS-1:0] prev_q;
  logic                armed_q;
  logic [NUM_PINS-1:0] edge_set;

  // Power-up sequencer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_OFF;
      dly_cnt <= '0;
    end else begin
      state   <= state_next;
      dly_cnt <= dly_cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    dly_cnt_next     = dly_cnt;
    pad_enable_h     = 1'b0;
    pad_enable_inp_h = 1'b0;
    pad_hld_h_n      = 1'b0;
    ready            = 1'b0;
    active           = 1'b0;
    case (state)
      ST_OFF: begin
        state_next   = ST_EN_H;
        dly_cnt_next = DLY_LOAD;
      end
      ST_EN_H: begin
        pad_enable_h = 1'b1;
        if (dly_cnt == '0) begin
          state_next   = ST_EN_INP;
          dly_cnt_next = DLY_LOAD;
        end else begin
          dly_cnt_next = dly_cnt - 8'd1;
        end
      end
      ST_EN_INP: begin
        pad_enable_h     = 1'b1;
        pad_enable_inp_h = 1'b1;
        if (dly_cnt == '0) begin
          state_next   = ST_RELEASE;
          dly_cnt_next = DLY_LOAD;
        end else begin
          dly_cnt_next = dly_cnt - 8'd1;
        end
      end
      ST_RELEASE: begin
        pad_enable_h     = 1'b1;
        pad_enable_inp_h = 1'b1;
        pad_hld_h_n      = 1'b1;
        if (dly_cnt == '0) begin
          state_next = ST_READY;
        end else begin
          dly_cnt_next = dly_cnt - 8'd1;
        end
      end
      ST_READY: begin
        pad_enable_h     = 1'b1;
        pad_enable_inp_h = 1'b1;
        pad_hld_h_n      = 1'b1;
        ready            = 1'b1;
        active           = 1'b1;
        if (hold_req) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        pad_enable_h     = 1'b1;
        pad_enable_inp_h = 1'b1;
        active           = 1'b1;
        if (!hold_req) state_next = ST_READY;
      end
      default: state_next = ST_OFF;
    endcase
  end

  // Pad controls are keyed on the next state so that READY entry and
  // HOLD release both see the configuration one cycle after it is applied.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pad_out     <= '0;
      pad_oe_n    <= '1;
      pad_dm      <= DM_SAFE;
      pad_inp_dis <= '0;
    end else if (state_next == ST_READY) begin
      pad_out     <= cfg_out;
      pad_oe_n    <= ~cfg_oe;
      pad_dm      <= cfg_dm;
      pad_inp_dis <= cfg_inp_dis;
    end else if (state_next != ST_HOLD) begin
      pad_out     <= '0;
      pad_oe_n    <= '1;
      pad_dm      <= DM_SAFE;
      pad_inp_dis <= '0;
    end
  end

  // Input synchroniser
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_PAD_BANK_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0]    deb_cnt [NUM_PINS];
  logic [NUM_PINS-1:0] deb_q;

  // Counter restarts whenever the synchronised value agrees with the
  // filtered value; the update fires on the DEBOUNCE_CYCLES-th differing sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= '0;
      for (int i = 0; i < NUM_PINS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (!active) begin
          deb_q[i]   <= 1'b0;
          deb_cnt[i] <= '0;
        end else if (cfg_inp_dis[i] || (sync_out[i] == deb_q[i])) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb_q[i]   <= sync_out[i];
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] != CNT_MAX) begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign gpio_in = deb_q;
`else
  // prev_q doubles as the held value for pins whose input buffer is disabled.
  always_comb begin
    gpio_in = '0;
    if (active) gpio_in = (cfg_inp_dis & prev_q) | (~cfg_inp_dis & sync_out);
  end
`endif

  // Edge detection: armed_q is low during the first active cycle, so the
  // jump of gpio_in from its forced-zero value on READY entry is not an edge.
  always_comb begin
    edge_set = '0;
    if (armed_q && active) begin
      edge_set = ((gpio_in & ~prev_q & cfg_irq_rise) |
                  (~gpio_in & prev_q & cfg_irq_fall)) & ~cfg_inp_dis;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      armed_q    <= 1'b0;
      irq_status <= '0;
    end else begin
      prev_q     <= gpio_in;
      armed_q    <= active;
      irq_status <= (irq_status & ~irq_clr) | edge_set;
    end
  end

  assign irq = |irq_status;

endmodule
